key_lockout_controller: RTL and testbench

Front-end controller that sequences the keypad into the digital lock FSM. It synchronises and debounces the four raw active-low DE1-SoC push-buttons and arbitrates simultaneous presses. It emits exactly one single-cycle one-hot key event per physical press. It also counts consecutive ERROR entries from the lock FSM and, after MAX_FAILS failures, blocks all key events for a timed lockout window.

---
 rtl/key_lockout_controller.sv | 176 +++++++++++++++++
 tb/tb_key_lockout_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_lockout_controller.sv
// Keypad front end for the digital lock FSM.
// Synchronises and debounces four active-low push-buttons, arbitrates simultaneous presses
// (key[0] highest priority) and emits one single-cycle one-hot event per accepted press.
// Counts consecutive lock FSM error entries; after MAX_FAILS of them all key events are
// blocked for LOCKOUT_CYCLES cycles.
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   key_n[3:0]  raw push-buttons, active-low, asynchronous to clock
//   error_flag  lock FSM error level, rising edge = one failure
//   lock_flag   lock FSM lock level, falling edge = successful unlock
//   key[3:0]    registered one-hot key event, one cycle per accepted press
//   lockout     high while key events are blocked
//   fail_count  current consecutive-failure count
module key_lockout_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_FAILS       = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 1500000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       error_flag,
    input  logic       lock_flag,
    output logic [3:0] key,
    output logic       lockout,
    output logic [3:0] fail_count
);

    localparam logic [31:0] DebLast  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LockLast = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]  FailMax  = 4'(MAX_FAILS);

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StHeld,
        StRelease,
        StLockout
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  sync1_q, sync2_q;
    logic        error_q, lock_q;
    logic [3:0]  cand_q, cand_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  key_q, key_d;
    logic        lockout_q, lockout_d;
    logic [3:0]  fail_q, fail_d;

    logic [3:0]  key_sync;
    logic        err_rise, lock_fall, enter_lockout;

    assign key_sync  = ~sync2_q;
    assign err_rise  = error_flag & ~error_q;
    assign lock_fall = ~lock_flag & lock_q;

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        key_d         = 4'd0;
        lockout_d     = lockout_q;
        fail_d        = fail_q;
        enter_lockout = 1'b0;

        // Failure bookkeeping is frozen during lockout; an error edge beats an unlock edge.
        if (state_q != StLockout) begin
            if (err_rise) begin
                if (fail_q != FailMax) begin
                    fail_d = fail_q + 4'd1;
                end
            end else if (lock_fall) begin
                fail_d = 4'd0;
            end
            enter_lockout = (fail_d == FailMax) && (fail_q != FailMax);
        end

        unique case (state_q)
            StIdle: begin
                if (key_sync != 4'd0) begin
                    cand_d  = key_sync;
                    cnt_d   = 32'd0;
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (key_sync == cand_q) begin
                    if (cnt_q == DebLast) begin
                        // Isolate the lowest set bit: key[0] wins ties.
                        key_d   = cand_q & (~cand_q + 4'd1);
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else if (key_sync == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cand_d = key_sync;
                    cnt_d  = 32'd0;
                end
            end
            StHeld: begin
                if (key_sync == 4'd0) begin
                    cnt_d   = 32'd0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (key_sync != 4'd0) begin
                    state_d = StHeld;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StLockout: begin
                if (timer_q == 32'd0) begin
                    lockout_d = 1'b0;
                    fail_d    = 4'd0;
                    // Anything still held must be released and pressed again.
                    state_d   = StHeld;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_lockout) begin
            state_d   = StLockout;
            lockout_d = 1'b1;
            timer_d   = LockLast;
            key_d     = 4'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            error_q   <= 1'b0;
            lock_q    <= 1'b0;
            state_q   <= StIdle;
            cand_q    <= 4'd0;
            cnt_q     <= 32'd0;
            timer_q   <= 32'd0;
            key_q     <= 4'd0;
            lockout_q <= 1'b0;
            fail_q    <= 4'd0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            error_q   <= error_flag;
            lock_q    <= lock_flag;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            key_q     <= key_d;
            lockout_q <= lockout_d;
            fail_q    <= fail_d;
        end
    end

    assign key        = key_q;
    assign lockout    = lockout_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_key_lockout_controller.sv
// Directed bench for key_lockout_controller with DEBOUNCE_CYCLES=4, MAX_FAILS=3,
// LOCKOUT_CYCLES=10. A vector table of {inputs, repeat count, expected outputs} covers the
// steady sequences; short hand-written sequences cover lockout-entry suppression and reset.
module tb_key_lockout_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       error_flag = 1'b0;
    logic       lock_flag = 1'b0;
    logic [3:0] key;
    logic       lockout;
    logic [3:0] fail_count;

    int total = 0;
    int bad   = 0;

    key_lockout_controller #(
        .DEBOUNCE_CYCLES(4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .error_flag(error_flag),
        .lock_flag (lock_flag),
        .key       (key),
        .lockout   (lockout),
        .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] kn;
        logic       err;
        logic       lck;
        int         reps;
        logic [3:0] exp_key;
        logic       exp_lockout;
        logic [3:0] exp_fail;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] kn, input logic err, input logic lck, input int reps,
                       input logic [3:0] ek, input logic el, input logic [3:0] ef);
        vec_t v;
        v.kn = kn; v.err = err; v.lck = lck; v.reps = reps;
        v.exp_key = ek; v.exp_lockout = el; v.exp_fail = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ek, input logic el,
                           input logic [3:0] ef);
        chk({tag, " key"}, key, ek);
        chk({tag, " lockout"}, {3'd0, lockout}, {3'd0, el});
        chk({tag, " fail_count"}, fail_count, ef);
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic [3:0] kn, input logic err, input logic lck);
        key_n = kn; error_flag = err; lock_flag = lck;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Press 4'b1101: event 4'b0010 on the 7th edge, nothing while held or on release.
        add(4'hF, 0, 0, 3, 4'h0, 0, 4'd0);
        add(4'hD, 0, 0, 6, 4'h0, 0, 4'd0);
        add(4'hD, 0, 0, 1, 4'h2, 0, 4'd0);
        add(4'hD, 0, 0, 10, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 10, 4'h0, 0, 4'd0);
        // key0 toggling every 2 cycles never survives debounce.
        for (int i = 0; i < 5; i++) begin
            add(4'hE, 0, 0, 2, 4'h0, 0, 4'd0);
            add(4'hF, 0, 0, 2, 4'h0, 0, 4'd0);
        end
        add(4'hF, 0, 0, 8, 4'h0, 0, 4'd0);
        // Keys 0 and 3 together: key0 wins; partial release silent; then key3 alone.
        add(4'h6, 0, 0, 6, 4'h0, 0, 4'd0);
        add(4'h6, 0, 0, 1, 4'h1, 0, 4'd0);
        add(4'h6, 0, 0, 8, 4'h0, 0, 4'd0);
        add(4'h7, 0, 0, 8, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 10, 4'h0, 0, 4'd0);
        add(4'h7, 0, 0, 6, 4'h0, 0, 4'd0);
        add(4'h7, 0, 0, 1, 4'h8, 0, 4'd0);
        add(4'h7, 0, 0, 4, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 10, 4'h0, 0, 4'd0);
        // Release bounce after an accepted key0 press.
        add(4'hE, 0, 0, 6, 4'h0, 0, 4'd0);
        add(4'hE, 0, 0, 1, 4'h1, 0, 4'd0);
        add(4'hE, 0, 0, 5, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 3, 4'h0, 0, 4'd0);
        add(4'hE, 0, 0, 1, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 2, 4'h0, 0, 4'd0);
        add(4'hE, 0, 0, 1, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 10, 4'h0, 0, 4'd0);
        // Three error edges -> lockout for exactly 10 cycles, key0 held throughout.
        add(4'hF, 1, 0, 1, 4'h0, 0, 4'd1);
        add(4'hF, 0, 0, 1, 4'h0, 0, 4'd1);
        add(4'hF, 1, 0, 1, 4'h0, 0, 4'd2);
        add(4'hF, 0, 0, 1, 4'h0, 0, 4'd2);
        add(4'hF, 1, 0, 1, 4'h0, 1, 4'd3);
        add(4'hE, 0, 0, 9, 4'h0, 1, 4'd3);
        add(4'hE, 0, 0, 10, 4'h0, 0, 4'd0);
        add(4'hF, 0, 0, 10, 4'h0, 0, 4'd0);
        add(4'hE, 0, 0, 6, 4'h0, 0, 4'd0);
        add(4'hE, 0, 0, 1, 4'h1, 0, 4'd0);
        add(4'hF, 0, 0, 10, 4'h0, 0, 4'd0);
        // Unlock clears the count; simultaneous error and unlock edges increment.
        add(4'hF, 0, 1, 2, 4'h0, 0, 4'd0);
        add(4'hF, 1, 1, 1, 4'h0, 0, 4'd1);
        add(4'hF, 0, 1, 1, 4'h0, 0, 4'd1);
        add(4'hF, 1, 1, 1, 4'h0, 0, 4'd2);
        add(4'hF, 0, 1, 1, 4'h0, 0, 4'd2);
        add(4'hF, 0, 0, 1, 4'h0, 0, 4'd0);
        add(4'hF, 1, 0, 1, 4'h0, 0, 4'd1);
        add(4'hF, 0, 0, 3, 4'h0, 0, 4'd1);
        add(4'hF, 0, 1, 1, 4'h0, 0, 4'd1);
        add(4'hF, 1, 0, 1, 4'h0, 0, 4'd2);
        add(4'hF, 0, 0, 2, 4'h0, 0, 4'd2);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset", 4'h0, 1'b0, 4'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                step(vecs[i].kn, vecs[i].err, vecs[i].lck);
                chk_all($sformatf("vec%0d.%0d", i, r), vecs[i].exp_key, vecs[i].exp_lockout,
                        vecs[i].exp_fail);
            end
        end

        // Third error lands on the edge that would issue the key0 event: event suppressed.
        for (int s = 0; s < 6; s++) begin
            step(4'hE, 1'b0, 1'b0);
            chk_all($sformatf("coin.pre%0d", s), 4'h0, 1'b0, 4'd2);
        end
        step(4'hE, 1'b1, 1'b0);
        chk_all("coin.entry", 4'h0, 1'b1, 4'd3);
        for (int s = 0; s < 9; s++) begin
            step(4'hF, 1'b0, 1'b0);
            chk_all($sformatf("coin.lock%0d", s), 4'h0, 1'b1, 4'd3);
        end
        for (int s = 0; s < 10; s++) begin
            step(4'hF, 1'b0, 1'b0);
            chk_all($sformatf("coin.post%0d", s), 4'h0, 1'b0, 4'd0);
        end

        // Reset mid-debounce clears everything at once and issues no event.
        step(4'hF, 1'b1, 1'b0);
        chk_all("rst.err", 4'h0, 1'b0, 4'd1);
        for (int s = 0; s < 4; s++) begin
            step(4'hE, 1'b0, 1'b0);
            chk_all($sformatf("rst.deb%0d", s), 4'h0, 1'b0, 4'd1);
        end
        reset = 1'b0;
        #1;
        chk_all("rst.async", 4'h0, 1'b0, 4'd0);
        key_n = 4'hF;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int s = 0; s < 10; s++) begin
            step(4'hF, 1'b0, 1'b0);
            chk_all($sformatf("rst.post%0d", s), 4'h0, 1'b0, 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
